// File: rtl/data_sampling_mv.sv
// Oversampling majority-vote bit sampler for a UART-style receiver.
// Votes are taken on a window centred on the middle of each bit period.
module data_sampling_mv #(
   parameter int unsigned PRESC_W     = 6,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RX_IN,
   input  logic               dat_samp_en,
   input  logic [PRESC_W-1:0] Prescale,
   input  logic [1:0]         samp_num,
   output logic               sampled_bit,
   output logic               sample_valid,
   output logic               noise_err,
   output logic [PRESC_W-1:0] edge_cnt
);

   logic rx_s;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign rx_s = RX_IN;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         logic [SYNC_STAGES:0]   sync_d;
         assign sync_d = {sync_q, RX_IN};
         always_ff @(posedge CLK) begin
            if (!RST) sync_q <= '1;
            else      sync_q <= sync_d[SYNC_STAGES-1:0];
         end
         assign rx_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   logic               en_q, en_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [1:0]         samp_q, samp_d;
   logic [PRESC_W-1:0] cnt_q, cnt_d;
   logic [2:0]         ones_q, ones_d;
   logic [2:0]         votes_q, votes_d;
   logic               bit_q, bit_d;
   logic               noise_q, noise_d;
   logic               valid_q, valid_d;

   logic [2:0]         n_votes;
   logic [2:0]         k_half;
   logic [PRESC_W-1:0] half;
   logic [PRESC_W-1:0] last;
   logic               in_win;
   logic               is_last;

   always_comb begin
      n_votes = 3'd3;
      k_half  = 3'd1;
      unique case (samp_q)
         2'b00:   begin n_votes = 3'd1; k_half = 3'd0; end
         2'b01:   begin n_votes = 3'd3; k_half = 3'd1; end
         2'b10:   begin n_votes = 3'd5; k_half = 3'd2; end
         default: begin n_votes = 3'd3; k_half = 3'd1; end
      endcase
   end

   // On the first enabled cycle cnt_q is 0, which can never hit the window or the
   // last-count compare for any clamped ratio, so the stale config is harmless there.
   assign half    = presc_q >> 1;
   assign last    = presc_q - PRESC_W'(1);
   assign in_win  = (cnt_q >= half - PRESC_W'(k_half)) && (cnt_q <= half + PRESC_W'(k_half));
   assign is_last = (cnt_q == last);

   always_comb begin
      en_d    = dat_samp_en;
      presc_d = presc_q;
      samp_d  = samp_q;
      cnt_d   = '0;
      ones_d  = '0;
      votes_d = '0;
      bit_d   = bit_q;
      noise_d = noise_q;
      valid_d = 1'b0;
      if (dat_samp_en && !en_q) begin
         presc_d = (Prescale < PRESC_W'(8)) ? PRESC_W'(8) : Prescale;
         samp_d  = samp_num;
      end
      if (dat_samp_en) begin
         if (is_last) begin
            bit_d   = (ones_q > (n_votes >> 1));
            noise_d = (ones_q != 3'd0) && (ones_q != n_votes);
            valid_d = 1'b1;
         end else begin
            cnt_d   = cnt_q + PRESC_W'(1);
            ones_d  = ones_q;
            votes_d = votes_q;
            if (in_win) begin
               ones_d  = ones_q + {2'b00, rx_s};
               votes_d = votes_q + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         en_q    <= 1'b0;
         presc_q <= PRESC_W'(8);
         samp_q  <= 2'b01;
         cnt_q   <= '0;
         ones_q  <= '0;
         votes_q <= '0;
         bit_q   <= 1'b0;
         noise_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         en_q    <= en_d;
         presc_q <= presc_d;
         samp_q  <= samp_d;
         cnt_q   <= cnt_d;
         ones_q  <= ones_d;
         votes_q <= votes_d;
         bit_q   <= bit_d;
         noise_q <= noise_d;
         valid_q <= valid_d;
      end
   end

   assign sampled_bit  = bit_q;
   assign noise_err    = noise_q;
   assign sample_valid = valid_q;
   assign edge_cnt     = dat_samp_en ? cnt_q : '0;

endmodule

// File: tb/tb_data_sampling_mv.sv
// Directed bench for data_sampling_mv: hand-computed vote outcomes, strobe timing,
// abort, clamping, config hold and mid-bit reset.
module tb_data_sampling_mv;

   localparam int unsigned PW = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic          RX_IN;
   logic          dat_samp_en;
   logic [PW-1:0] Prescale;
   logic [1:0]    samp_num;
   logic          sampled_bit;
   logic          sample_valid;
   logic          noise_err;
   logic [PW-1:0] edge_cnt;

   int checks = 0;
   int errors = 0;
   int strobes;

   data_sampling_mv #(.PRESC_W(PW), .SYNC_STAGES(2)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_IN        (RX_IN),
      .dat_samp_en  (dat_samp_en),
      .Prescale     (Prescale),
      .samp_num     (samp_num),
      .sampled_bit  (sampled_bit),
      .sample_valid (sample_valid),
      .noise_err    (noise_err),
      .edge_cnt     (edge_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic b, input logic n);
      check({tag, "_valid"}, {31'd0, sample_valid}, {31'd0, v});
      check({tag, "_bit"},   {31'd0, sampled_bit},  {31'd0, b});
      check({tag, "_noise"}, {31'd0, noise_err},    {31'd0, n});
   endtask

   initial begin
      RST = 1'b0; RX_IN = 1'b1; dat_samp_en = 1'b0; Prescale = 6'd16; samp_num = 2'b01;
      @(negedge CLK);
      tick(); tick();
      check_out("reset", 1'b0, 1'b0, 1'b0);
      check("reset_cnt", {26'd0, edge_cnt}, 32'd0);
      RST = 1'b1;
      tick(); tick(); tick();

      // P=16, N=3: lows outside window 7..9 ignored, then one low vote in bit 2
      Prescale = 6'd16; samp_num = 2'b01; dat_samp_en = 1'b1; strobes = 0;
      for (int i = 0; i < 32; i++) begin
         RX_IN = (i == 4 || i == 8 || i == 21) ? 1'b0 : 1'b1;
         tick();
         if (sample_valid) strobes++;
         if (i == 14) begin
            check("t1_cnt15", {26'd0, edge_cnt}, 32'd15);
            check("t1_novalid", {31'd0, sample_valid}, 32'd0);
         end
         if (i == 15) begin
            check_out("t1_bit1", 1'b1, 1'b1, 1'b0);
            check("t1_wrap", {26'd0, edge_cnt}, 32'd0);
         end
         if (i == 31) check_out("t1_bit2", 1'b1, 1'b1, 1'b1);
      end
      check("t1_strobes", strobes, 32'd2);

      dat_samp_en = 1'b0; RX_IN = 1'b0;
      tick();
      check_out("idle_hold", 1'b0, 1'b1, 1'b1);
      check("idle_cnt", {26'd0, edge_cnt}, 32'd0);
      tick(); tick();

      // P=8, N=5: single high vote at edge_cnt 4
      Prescale = 6'd8; samp_num = 2'b10; dat_samp_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         RX_IN = (i == 2) ? 1'b1 : 1'b0;
         tick();
         if (i == 7) check_out("t2_glitch", 1'b1, 1'b0, 1'b1);
      end
      dat_samp_en = 1'b0;
      tick();

      // P=32, N=1: only edge_cnt 16 matters; period 32
      Prescale = 6'd32; samp_num = 2'b00; dat_samp_en = 1'b1; strobes = 0;
      for (int i = 0; i < 64; i++) begin
         RX_IN = (i == 14) ? 1'b1 : 1'b0;
         tick();
         if (sample_valid) strobes++;
         if (i == 30) check("t3_novalid", {31'd0, sample_valid}, 32'd0);
         if (i == 31) check_out("t3_bit1", 1'b1, 1'b1, 1'b0);
         if (i == 63) check_out("t3_bit2", 1'b1, 1'b0, 1'b0);
      end
      check("t3_strobes", strobes, 32'd2);
      dat_samp_en = 1'b0; RX_IN = 1'b1;
      tick(); tick(); tick();

      // P=16 abort at edge_cnt 10, then restart; config change while enabled ignored
      Prescale = 6'd16; samp_num = 2'b01; dat_samp_en = 1'b1; strobes = 0;
      for (int i = 0; i < 10; i++) tick();
      check("t4_cnt10", {26'd0, edge_cnt}, 32'd10);
      dat_samp_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (sample_valid) strobes++;
      end
      check("t4_abort_cnt", {26'd0, edge_cnt}, 32'd0);
      dat_samp_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 3) begin Prescale = 6'd8; samp_num = 2'b10; end
         tick();
         if (sample_valid) strobes++;
         if (i == 14) check("t4_cnt15", {26'd0, edge_cnt}, 32'd15);
         if (i == 15) check_out("t4_restart", 1'b1, 1'b1, 1'b0);
      end
      check("t4_strobes", strobes, 32'd1);

      // Prescale 4 clamps to 8; samp_num 11 means N=3, window 3..5
      dat_samp_en = 1'b0; Prescale = 6'd4; samp_num = 2'b11;
      tick();
      dat_samp_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         RX_IN = (i == 0 || i == 4 || i == 9) ? 1'b0 : 1'b1;
         tick();
         if (i == 3) check("t5_no_early", {31'd0, sample_valid}, 32'd0);
         if (i == 6) check("t5_cnt7", {26'd0, edge_cnt}, 32'd7);
         if (i == 7) check_out("t5_bit1", 1'b1, 1'b1, 1'b0);
         if (i == 15) check_out("t5_bit2", 1'b1, 1'b1, 1'b1);
      end

      // Reset mid-bit at edge_cnt 12, then count resumes from 0
      dat_samp_en = 1'b0; RX_IN = 1'b1;
      tick();
      Prescale = 6'd16; samp_num = 2'b01; dat_samp_en = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check("t6_cnt12", {26'd0, edge_cnt}, 32'd12);
      RST = 1'b0;
      tick();
      check_out("t6_rst", 1'b0, 1'b0, 1'b0);
      check("t6_rst_cnt", {26'd0, edge_cnt}, 32'd0);
      RST = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 14) begin
            check("t6_cnt15", {26'd0, edge_cnt}, 32'd15);
            check("t6_novalid", {31'd0, sample_valid}, 32'd0);
         end
         if (i == 15) check_out("t6_bit", 1'b1, 1'b1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
